ctr_keystream_collector: RTL and testbench



---
 rtl/aes_ctr_pkg.sv | 26 ++
 rtl/ctr_lane_write_arb.sv | 44 ++++
 rtl/ctr_keystream_collector.sv | 153 +++++++++++++++
 tb/tb_ctr_keystream_collector.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctr_pkg.sv
// Shared definitions for the AES-256 CTR keystream path: block/counter sizing,
// mode encodings and the collector state enum.
package aes_ctr_pkg;

  localparam int BLOCK_SIZE = 128;
  localparam int CNT_W      = 6;
  localparam int DEPTH      = 48;
  localparam int LANES      = 3;
  localparam int XOF_BLOCKS = 44;
  localparam int PRF_BLOCKS = 8;

  localparam logic MODE_XOF = 1'b0;
  localparam logic MODE_PRF = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } coll_state_e;

  // Number of blocks to emit before the collector declares itself finished.
  function automatic logic [CNT_W-1:0] target_for_mode(input logic m);
    return (m == MODE_PRF) ? CNT_W'(PRF_BLOCKS) : CNT_W'(XOF_BLOCKS);
  endfunction

endpackage

// File: rtl/ctr_lane_write_arb.sv
// Combinational write arbitration for one engine beat: drops lanes whose
// counter is outside the target range, lets the lowest lane win a same-beat
// collision and refuses writes to slots that are already occupied.
module ctr_lane_write_arb
  import aes_ctr_pkg::*;
(
  input  logic                   in_valid,
  input  logic [LANES*CNT_W-1:0] in_cnt,
  input  logic [CNT_W-1:0]       target,
  input  logic [DEPTH-1:0]       bitmap,
  output logic [DEPTH-1:0]       wr_en,
  output logic [LANES-1:0]       lane_wr,
  output logic                   dup
);

  logic [CNT_W-1:0] lane_cnt [LANES];

  // Unpack the per-lane counter tags; lane0 sits in the MSBs.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_cnt[l] = in_cnt[(LANES-1-l)*CNT_W +: CNT_W];
    end
  end

  // Lanes are visited lowest first so an earlier lane's claim on a slot makes
  // a later lane with the same tag look like a duplicate. A slot being drained
  // this cycle still has its bitmap bit set, so a write to it is refused too.
  always_comb begin
    wr_en   = '0;
    lane_wr = '0;
    dup     = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (in_valid && (lane_cnt[l] < target)) begin
        if (bitmap[lane_cnt[l]] || wr_en[lane_cnt[l]]) begin
          dup = 1'b1;
        end else begin
          wr_en[lane_cnt[l]] = 1'b1;
          lane_wr[l]         = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ctr_keystream_collector.sv
// Reorders keystream blocks from the 3-lane CTR engine into strict counter
// order and streams them out on a valid/ready interface.
// Optional build macro CTR_COLLECTOR_XOR_EN: XORs each block with a data_in
// word so the block performs CTR encrypt/decrypt in-line.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | after reset; input beats ignored, no output
// ST_COLLECT | buffering blocks by counter and emitting them in order
// ST_DONE    | target block count emitted; finished held until start/reset
module ctr_keystream_collector
  import aes_ctr_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        mode,
  input  logic                        in_valid,
  input  logic [LANES*BLOCK_SIZE-1:0] in_blocks,
  input  logic [LANES*CNT_W-1:0]      in_cnt,
`ifdef CTR_COLLECTOR_XOR_EN
  input  logic [BLOCK_SIZE-1:0]       data_in,
  input  logic                        data_valid,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BLOCK_SIZE-1:0]       out_block,
  output logic [CNT_W-1:0]            out_idx,
  output logic                        busy,
  output logic                        finished,
  output logic                        err_dup
);

  coll_state_e           state_q, state_d;
  logic [DEPTH-1:0]      bitmap_q, bitmap_d;
  logic [CNT_W-1:0]      next_idx_q, next_idx_d;
  logic [CNT_W-1:0]      target_q, target_d;
  logic                  err_dup_q, err_dup_d;
  logic                  finished_q, finished_d;
  logic [BLOCK_SIZE-1:0] kbuf_q [DEPTH];

  logic [BLOCK_SIZE-1:0] lane_blk [LANES];
  logic [CNT_W-1:0]      lane_cnt [LANES];
  logic                  arb_valid;
  logic [DEPTH-1:0]      arb_wr_en;
  logic [LANES-1:0]      arb_lane_wr;
  logic                  arb_dup;
  logic                  ks_valid;
  logic                  handshake;
  logic [BLOCK_SIZE-1:0] head_blk;

  // Unpack lane data and tags; lane0 sits in the MSBs.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_blk[l] = in_blocks[(LANES-1-l)*BLOCK_SIZE +: BLOCK_SIZE];
      lane_cnt[l] = in_cnt[(LANES-1-l)*CNT_W +: CNT_W];
    end
  end

  // start wins over a coincident beat, so that beat never reaches the buffer.
  assign arb_valid = in_valid && !start && (state_q == ST_COLLECT);

  ctr_lane_write_arb u_arb (
    .in_valid (arb_valid),
    .in_cnt   (in_cnt),
    .target   (target_q),
    .bitmap   (bitmap_q),
    .wr_en    (arb_wr_en),
    .lane_wr  (arb_lane_wr),
    .dup      (arb_dup)
  );

  // Output stage: the head slot is presented as soon as its bitmap bit is set;
  // the block bus is forced to zero whenever nothing valid is presented.
  always_comb begin
    head_blk = kbuf_q[next_idx_q];
    ks_valid = (state_q == ST_COLLECT) && bitmap_q[next_idx_q];
`ifdef CTR_COLLECTOR_XOR_EN
    out_valid = ks_valid && data_valid;
    out_block = out_valid ? (head_blk ^ data_in) : '0;
`else
    out_valid = ks_valid;
    out_block = out_valid ? head_blk : '0;
`endif
    out_idx   = next_idx_q;
    busy      = (state_q == ST_COLLECT);
    finished  = finished_q;
    err_dup   = err_dup_q;
    handshake = out_valid && out_ready;
  end

  // Next-state: start restarts from any state; otherwise collect writes and
  // retire the head slot on each handshake until the target count is reached.
  always_comb begin
    state_d    = state_q;
    bitmap_d   = bitmap_q;
    next_idx_d = next_idx_q;
    target_d   = target_q;
    err_dup_d  = err_dup_q;
    finished_d = finished_q;
    if (start) begin
      state_d    = ST_COLLECT;
      bitmap_d   = '0;
      next_idx_d = '0;
      target_d   = target_for_mode(mode);
      err_dup_d  = 1'b0;
      finished_d = 1'b0;
    end else if (state_q == ST_COLLECT) begin
      bitmap_d = bitmap_q | arb_wr_en;
      if (arb_dup) begin
        err_dup_d = 1'b1;
      end
      if (handshake) begin
        bitmap_d[next_idx_q] = 1'b0;
        next_idx_d           = next_idx_q + CNT_W'(1);
        if (next_idx_q == (target_q - CNT_W'(1))) begin
          state_d    = ST_DONE;
          finished_d = 1'b1;
        end
      end
    end
  end

  // Control registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bitmap_q   <= '0;
      next_idx_q <= '0;
      target_q   <= CNT_W'(XOF_BLOCKS);
      err_dup_q  <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitmap_q   <= bitmap_d;
      next_idx_q <= next_idx_d;
      target_q   <= target_d;
      err_dup_q  <= err_dup_d;
      finished_q <= finished_d;
    end
  end

  // Keystream buffer: no reset needed, validity lives in the bitmap. The
  // arbiter guarantees accepted lanes carry distinct tags.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (arb_lane_wr[l]) begin
        kbuf_q[lane_cnt[l]] <= lane_blk[l];
      end
    end
  end

endmodule

// File: tb/tb_ctr_keystream_collector.sv
// Scoreboard bench for ctr_keystream_collector: stimulus pushes expected
// (index, block) pairs, a monitor pops and compares on every handshake.
module tb_ctr_keystream_collector;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic         in_valid = 1'b0;
  logic [383:0] in_blocks = '0;
  logic [17:0]  in_cnt = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_block;
  logic [5:0]   out_idx;
  logic         busy;
  logic         finished;
  logic         err_dup;
`ifdef CTR_COLLECTOR_XOR_EN
  logic [127:0] data_in = '1;
  logic         data_valid = 1'b1;
  localparam logic [127:0] XMASK = '1;
`else
  localparam logic [127:0] XMASK = '0;
`endif

  ctr_keystream_collector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_blocks  (in_blocks),
    .in_cnt     (in_cnt),
`ifdef CTR_COLLECTOR_XOR_EN
    .data_in    (data_in),
    .data_valid (data_valid),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_block  (out_block),
    .out_idx    (out_idx),
    .busy       (busy),
    .finished   (finished),
    .err_dup    (err_dup)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]   idx;
    logic [127:0] blk;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;

  function automatic logic [127:0] blk(input logic [7:0] seed, input logic [5:0] c);
    return {4{seed, 2'b01, c, 16'hA5C3}};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every handshake must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      hs_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got idx %0d blk %h expected no output", out_idx, out_block);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_idx !== e.idx || out_block !== e.blk) begin
          errors++;
          $display("FAIL out_data: got idx %0d blk %h expected idx %0d blk %h",
                   out_idx, out_block, e.idx, e.blk);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input logic [127:0] ks);
    exp_t e;
    e.idx = 6'(idx);
    e.blk = ks ^ XMASK;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic m);
    start = 1'b1;
    mode  = m;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input int c0, input int c1, input int c2,
                      input logic [127:0] b0, input logic [127:0] b1, input logic [127:0] b2);
    in_valid  = 1'b1;
    in_cnt    = {6'(c0), 6'(c1), 6'(c2)};
    in_blocks = {b0, b1, b2};
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic beat_s(input int c0, input int c1, input int c2, input logic [7:0] s);
    beat(c0, c1, c2, blk(s, 6'(c0)), blk(s, 6'(c1)), blk(s, 6'(c2)));
  endtask

  task automatic wait_finished(input string name, input int budget);
    int n;
    n = 0;
    while (!finished && n < budget) begin
      tick();
      n++;
    end
    chk(name, 128'(finished), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    int k;
    logic [127:0] held_blk;
    logic [5:0]   held_idx;

    // Reset state
    #12;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_finished", 128'(finished), 128'(0));
    chk("rst_err_dup", 128'(err_dup), 128'(0));
    chk("rst_out_idx", 128'(out_idx), 128'(0));
    chk("rst_out_block", out_block, 128'(0));
    rst_n = 1'b1;
    tick();

    // PRF: 8 blocks, counters >= 8 ignored
    do_start(1'b1);
    chk("prf_busy", 128'(busy), 128'(1));
    for (int i = 0; i < 8; i++) push(i, blk(8'h11, 6'(i)));
    hs0 = hs_cnt;
    out_ready = 1'b1;
    for (int b = 0; b < 7; b++) beat_s(b, b + 7, b + 16, 8'h11);
    wait_finished("prf_finished", 40);
    chk("prf_hs_count", 128'(hs_cnt - hs0), 128'(8));
    chk("prf_busy_done", 128'(busy), 128'(0));
    chk("prf_valid_done", 128'(out_valid), 128'(0));
    beat_s(0, 1, 2, 8'h99);
    tick();
    chk("done_ignores_beat", 128'(out_valid), 128'(0));
    chk("prf_err_dup", 128'(err_dup), 128'(0));
    chk("prf_queue_empty", 128'(exp_q.size()), 128'(0));
    out_ready = 1'b0;

    // XOF: 48 counters interleaved, random ready, 44 emitted
    do_start(1'b0);
    for (int i = 0; i < 44; i++) push(i, blk(8'h22, 6'(i)));
    hs0 = hs_cnt;
    k = 0;
    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (k < 16) begin
        in_valid  = 1'b1;
        in_cnt    = {6'(k), 6'(k + 16), 6'(k + 32)};
        in_blocks = {blk(8'h22, 6'(k)), blk(8'h22, 6'(k + 16)), blk(8'h22, 6'(k + 32))};
        k++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("xof_finished", 128'(finished), 128'(1));
    chk("xof_hs_count", 128'(hs_cnt - hs0), 128'(44));
    out_ready = 1'b1;
    repeat (3) tick();
    chk("xof_no_extra", 128'(hs_cnt - hs0), 128'(44));
    chk("xof_queue_empty", 128'(exp_q.size()), 128'(0));
    out_ready = 1'b0;

    // Backpressure hold on counter 0
    do_start(1'b1);
    beat_s(0, 60, 61, 8'h33);
    chk("hold_valid0", 128'(out_valid), 128'(1));
    held_blk = out_block;
    held_idx = out_idx;
    chk("hold_blk0", held_blk, blk(8'h33, 6'd0) ^ XMASK);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("hold_valid", 128'(out_valid), 128'(1));
      chk("hold_blk", out_block, held_blk);
      chk("hold_idx", 128'(out_idx), 128'(held_idx));
    end
    push(0, blk(8'h33, 6'd0));
    hs0 = hs_cnt;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    chk("hold_one_hs", 128'(hs_cnt - hs0), 128'(1));
    chk("hold_next_idx", 128'(out_idx), 128'(1));
    chk("hold_valid_after", 128'(out_valid), 128'(0));

    // Duplicates and same-beat collision
    do_start(1'b0);
    beat_s(3, 50, 51, 8'h41);
    chk("dup_clear", 128'(err_dup), 128'(0));
    beat_s(3, 60, 61, 8'h42);
    chk("dup_set", 128'(err_dup), 128'(1));
    beat(5, 5, 6, blk(8'h51, 6'd5), blk(8'h52, 6'd5), blk(8'h53, 6'd6));
    beat_s(0, 1, 2, 8'h44);
    beat_s(4, 62, 63, 8'h44);
    push(0, blk(8'h44, 6'd0));
    push(1, blk(8'h44, 6'd1));
    push(2, blk(8'h44, 6'd2));
    push(3, blk(8'h41, 6'd3));
    push(4, blk(8'h44, 6'd4));
    push(5, blk(8'h51, 6'd5));
    push(6, blk(8'h53, 6'd6));
    hs0 = hs_cnt;
    out_ready = 1'b1;
    repeat (10) tick();
    out_ready = 1'b0;
    chk("dup_hs_count", 128'(hs_cnt - hs0), 128'(7));
    chk("dup_stop_idx", 128'(out_idx), 128'(7));
    chk("dup_sticky", 128'(err_dup), 128'(1));

    // Asynchronous reset mid-collection
    do_start(1'b0);
    beat_s(0, 1, 2, 8'h61);
    beat_s(3, 4, 5, 8'h61);
    beat_s(6, 7, 8, 8'h61);
    beat_s(9, 62, 63, 8'h61);
    chk("rst_pre_valid", 128'(out_valid), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 128'(out_valid), 128'(0));
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_finished", 128'(finished), 128'(0));
    chk("arst_idx", 128'(out_idx), 128'(0));
    tick();
    rst_n = 1'b1;
    tick();
    do_start(1'b1);
    hs0 = hs_cnt;
    out_ready = 1'b1;
    repeat (5) tick();
    chk("arst_no_stale", 128'(out_valid), 128'(0));
    chk("arst_no_stale_hs", 128'(hs_cnt - hs0), 128'(0));
    push(0, blk(8'h71, 6'd0));
    beat_s(0, 60, 61, 8'h71);
    repeat (2) tick();
    chk("arst_fresh_hs", 128'(hs_cnt - hs0), 128'(1));
    out_ready = 1'b0;

`ifdef CTR_COLLECTOR_XOR_EN
    // In-line XOR with data_in
    do_start(1'b1);
    data_valid = 1'b0;
    data_in    = '1;
    beat(0, 60, 61, {8{16'h00FF}}, '0, '0);
    chk("xor_gated", 128'(out_valid), 128'(0));
    data_valid = 1'b1;
    #1;
    chk("xor_valid", 128'(out_valid), 128'(1));
    chk("xor_block", out_block, {8{16'hFF00}});
    push(0, {8{16'h00FF}});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
`endif

    tick();
    chk("final_queue_empty", 128'(exp_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
